// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg : shared types and default widths for the pipeline-stage register
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pipe_pkg;

   localparam int PIPE_CTRL_W  = 16;
   localparam int PIPE_DATA_W  = 32;
   localparam int PIPE_NUM_OPS = 3;
   localparam int PIPE_TAG_W   = 4;

   localparam logic [PIPE_CTRL_W-1:0] PIPE_NOP_CTRL = '0;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } stage_st_t;

endpackage

`default_nettype wire

// File: rtl/pipe_slot.sv
// ---------------------------------------------------------------------------
// pipe_slot : valid-qualified payload register with load, clear and async CLR
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipe_slot #(
   parameter int W = 8
) (
   input  logic         CLK,
   input  logic         CLR,
   input  logic         i_load,
   input  logic         i_clear,
   input  logic [W-1:0] i_d,
   output logic         o_valid,
   output logic [W-1:0] o_q
);

   logic         r_valid;
   logic [W-1:0] r_q;

   // Clear only drops the valid bit; the payload keeps its last value.
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         r_valid <= 1'b0;
         r_q     <= '0;
      end else begin
         if (i_clear) begin
            r_valid <= 1'b0;
         end else if (i_load) begin
            r_valid <= 1'b1;
         end
         if (i_load && !i_clear) begin
            r_q <= i_d;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_q     = r_q;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg : valid/ready pipeline-stage register with flush-to-bubble;
//                  optional skid slot enabled by macro PIPE_STAGE_SKID_EN
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int CTRL_W  = PIPE_CTRL_W,
   parameter int DATA_W  = PIPE_DATA_W,
   parameter int NUM_OPS = PIPE_NUM_OPS,
   parameter int TAG_W   = PIPE_TAG_W
) (
   input  logic                      CLK,
   input  logic                      CLR,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [CTRL_W-1:0]         in_ctrl,
   input  logic [NUM_OPS*DATA_W-1:0] in_ops,
   input  logic [TAG_W-1:0]          in_tag,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [CTRL_W-1:0]         out_ctrl,
   output logic [NUM_OPS*DATA_W-1:0] out_ops,
   output logic [TAG_W-1:0]          out_tag
);

   localparam int c_OPS_W = NUM_OPS * DATA_W;
   localparam int c_PAY_W = CTRL_W + c_OPS_W + TAG_W;

   stage_st_t            r_state;
   stage_st_t            w_nxt_state;
   logic                 w_in_xfer;
   logic                 w_out_xfer;
   logic [c_PAY_W-1:0]   w_in_pay;
   logic [c_PAY_W-1:0]   w_main_d;
   logic [c_PAY_W-1:0]   w_main_q;
   logic                 w_main_vld;
   logic                 w_main_load;
   logic                 w_main_clear;
   logic [CTRL_W-1:0]    w_main_ctrl;

   assign w_in_pay   = {in_ctrl, in_ops, in_tag};
   assign w_in_xfer  = in_valid && in_ready;
   assign w_out_xfer = out_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
   logic               w_skid_load;
   logic               w_skid_clear;
   logic               w_skid_vld;
   logic [c_PAY_W-1:0] w_skid_q;

   // Ready depends only on held state, so out_ready never reaches in_ready.
   assign in_ready = (r_state != TWO);
   assign w_main_d = w_skid_vld ? w_skid_q : w_in_pay;

   always_comb begin
      w_nxt_state  = r_state;
      w_main_load  = 1'b0;
      w_main_clear = 1'b0;
      w_skid_load  = 1'b0;
      w_skid_clear = 1'b0;
      if (flush) begin
         w_nxt_state  = EMPTY;
         w_main_clear = 1'b1;
         w_skid_clear = 1'b1;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_in_xfer) begin
                  w_main_load = 1'b1;
                  w_nxt_state = ONE;
               end
            end
            ONE: begin
               if (w_in_xfer && w_out_xfer) begin
                  w_main_load = 1'b1;
               end else if (w_in_xfer) begin
                  w_skid_load = 1'b1;
                  w_nxt_state = TWO;
               end else if (w_out_xfer) begin
                  w_main_clear = 1'b1;
                  w_nxt_state  = EMPTY;
               end
            end
            TWO: begin
               if (w_out_xfer) begin
                  w_main_load  = 1'b1;
                  w_skid_clear = 1'b1;
                  w_nxt_state  = ONE;
               end
            end
            default: w_nxt_state = EMPTY;
         endcase
      end
   end

   pipe_slot #(.W(c_PAY_W)) u_skid (
      .CLK     (CLK),
      .CLR     (CLR),
      .i_load  (w_skid_load),
      .i_clear (w_skid_clear),
      .i_d     (w_in_pay),
      .o_valid (w_skid_vld),
      .o_q     (w_skid_q)
   );
`else
   assign in_ready = out_ready || !out_valid;
   assign w_main_d = w_in_pay;

   always_comb begin
      w_nxt_state  = r_state;
      w_main_load  = 1'b0;
      w_main_clear = 1'b0;
      if (flush) begin
         w_nxt_state  = EMPTY;
         w_main_clear = 1'b1;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_in_xfer) begin
                  w_main_load = 1'b1;
                  w_nxt_state = ONE;
               end
            end
            ONE: begin
               if (w_in_xfer) begin
                  w_main_load = 1'b1;
               end else if (w_out_xfer) begin
                  w_main_clear = 1'b1;
                  w_nxt_state  = EMPTY;
               end
            end
            default: w_nxt_state = EMPTY;
         endcase
      end
   end
`endif

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         r_state <= EMPTY;
      end else begin
         r_state <= w_nxt_state;
      end
   end

   pipe_slot #(.W(c_PAY_W)) u_main (
      .CLK     (CLK),
      .CLR     (CLR),
      .i_load  (w_main_load),
      .i_clear (w_main_clear),
      .i_d     (w_main_d),
      .o_valid (w_main_vld),
      .o_q     (w_main_q)
   );

   assign {w_main_ctrl, out_ops, out_tag} = w_main_q;
   assign out_valid = w_main_vld;
   // An empty stage presents a NOP bubble on the control bundle.
   assign out_ctrl  = w_main_vld ? w_main_ctrl : CTRL_W'(PIPE_NOP_CTRL);

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg : self-checking bench with a FIFO-queue reference model
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pipe_stage_reg;

   localparam int CW = 16;
   localparam int DW = 32;
   localparam int NO = 3;
   localparam int TW = 4;
   localparam int OW = NO * DW;
`ifdef PIPE_STAGE_SKID_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif

   logic          CLK = 1'b0;
   logic          CLR;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [CW-1:0] in_ctrl;
   logic [OW-1:0] in_ops;
   logic [TW-1:0] in_tag;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] out_ctrl;
   logic [OW-1:0] out_ops;
   logic [TW-1:0] out_tag;

   pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .NUM_OPS(NO), .TAG_W(TW)) dut (
      .CLK       (CLK),
      .CLR       (CLR),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ctrl   (in_ctrl),
      .in_ops    (in_ops),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ctrl  (out_ctrl),
      .out_ops   (out_ops),
      .out_tag   (out_tag)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [CW-1:0] c;
      logic [OW-1:0] o;
      logic [TW-1:0] t;
   } ent_t;

   ent_t q[$];
   ent_t last;
   int   errs   = 0;
   int   checks = 0;
   bit   m_rdy;

   function automatic bit exp_ready();
      if (DEPTH == 2) return q.size() < 2;
      return out_ready || (q.size() == 0);
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare();
      ent_t f;
      f = (q.size() > 0) ? q[0] : '0;
      chk("out_valid", 128'(out_valid), 128'(q.size() > 0));
      chk("out_ctrl", 128'(out_ctrl), 128'((q.size() > 0) ? f.c : '0));
      chk("out_ops", 128'(out_ops), 128'(last.o));
      chk("out_tag", 128'(out_tag), 128'(last.t));
      chk("in_ready", 128'(in_ready), 128'(exp_ready()));
   endtask

   // One clock cycle: drive, compare against the model, then advance the model.
   task automatic step(input bit v, input logic [CW-1:0] c, input logic [OW-1:0] o,
                       input logic [TW-1:0] t, input bit ordy, input bit fl);
      ent_t e;
      bit   in_x, out_x;
      @(negedge CLK);
      in_valid = v; in_ctrl = c; in_ops = o; in_tag = t; out_ready = ordy; flush = fl;
      #1;
      compare();
      m_rdy = exp_ready();
      in_x  = v && m_rdy;
      out_x = (q.size() > 0) && ordy;
      e.c = c; e.o = o; e.t = t;
      if (fl) begin
         q.delete();
      end else begin
         if (out_x) void'(q.pop_front());
         if (in_x) q.push_back(e);
      end
      if (q.size() > 0) last = q[0];
   endtask

   function automatic logic [OW-1:0] rops();
      return {$urandom, $urandom, $urandom};
   endfunction

   initial begin
      int         nxt;
      logic [3:0] seen[$];

      CLR = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_ctrl = '0; in_ops = '0; in_tag = '0;
      last = '0;
      @(negedge CLK); #1;
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_out_ctrl", 128'(out_ctrl), 128'(0));
      chk("rst_out_ops", 128'(out_ops), 128'(0));
      chk("rst_out_tag", 128'(out_tag), 128'(0));
      chk("rst_in_ready", 128'(in_ready), 128'(1));
      CLR = 1'b0;

      // Streaming tags 0..7 with continuous out_ready.
      for (int i = 0; i <= 8; i++) begin
         step(i < 8, 16'h0100 | 16'(i), rops(), 4'(i), 1'b1, 1'b0);
         if (i > 0) begin
            chk("stream_valid", 128'(out_valid), 128'(1));
            chk("stream_tag", 128'(out_tag), 128'(i - 1));
         end
      end
      step(1'b0, '0, '0, '0, 1'b1, 1'b0);

      // Lane k carries 0xA000000k.
      step(1'b1, 16'h0001, {32'hA0000002, 32'hA0000001, 32'hA0000000}, 4'd5, 1'b1, 1'b0);
      step(1'b0, '0, '0, '0, 1'b1, 1'b0);
      for (int k = 0; k < NO; k++)
         chk("lane", 128'(out_ops[k*DW +: DW]), 128'(32'hA0000000 + k));
      step(1'b0, '0, '0, '0, 1'b1, 1'b0);

      // Backpressure: out_ready low for 5 cycles while offering 1,2,3.
      nxt = 1;
      for (int i = 0; i < 5; i++) begin
         step(nxt <= 3, 16'h0200 | 16'(nxt), rops(), 4'(nxt), 1'b0, 1'b0);
         if (m_rdy && nxt <= 3) nxt++;
      end
      chk("bp_hold_tag", 128'(out_tag), 128'(1));
      chk("bp_in_ready", 128'(in_ready), 128'(0));
      chk("bp_accepted", 128'(nxt), 128'(DEPTH + 1));
      for (int i = 0; i < 10; i++) begin
         step(nxt <= 3, 16'h0200 | 16'(nxt), rops(), 4'(nxt), 1'b1, 1'b0);
         if (out_valid) seen.push_back(out_tag);
         if (m_rdy && nxt <= 3) nxt++;
      end
      chk("bp_count", 128'(seen.size()), 128'(3));
      for (int i = 0; i < 3 && i < seen.size(); i++)
         chk("bp_order", 128'(seen[i]), 128'(i + 1));

      // Flush while full with an input offered.
      step(1'b1, 16'h0309, rops(), 4'd9, 1'b0, 1'b0);
      step(1'b1, 16'h030A, rops(), 4'd10, 1'b0, 1'b0);
      step(1'b1, 16'h030B, rops(), 4'd11, 1'b0, 1'b1);
      step(1'b0, '0, '0, '0, 1'b1, 1'b0);
      chk("flush_valid", 128'(out_valid), 128'(0));
      chk("flush_ctrl", 128'(out_ctrl), 128'(0));
      for (int i = 0; i < 3; i++) step(1'b0, '0, '0, '0, 1'b1, 1'b0);

      // Simultaneous in and out while holding one entry.
      step(1'b1, 16'h0404, rops(), 4'd4, 1'b1, 1'b0);
      step(1'b1, 16'h0405, rops(), 4'd5, 1'b1, 1'b0);
      chk("simul_first", 128'(out_tag), 128'(4));
      step(1'b0, '0, '0, '0, 1'b1, 1'b0);
      chk("simul_replaced", 128'(out_tag), 128'(5));
      chk("simul_valid", 128'(out_valid), 128'(1));
      step(1'b0, '0, '0, '0, 1'b1, 1'b0);

      // Asynchronous CLR while an entry is presented.
      step(1'b1, 16'h0506, rops(), 4'd6, 1'b0, 1'b0);
      step(1'b0, '0, '0, '0, 1'b0, 1'b0);
      #2 CLR = 1'b1;
      #1;
      chk("clr_valid", 128'(out_valid), 128'(0));
      chk("clr_ctrl", 128'(out_ctrl), 128'(0));
      chk("clr_ops", 128'(out_ops), 128'(0));
      chk("clr_tag", 128'(out_tag), 128'(0));
      q.delete();
      last = '0;
      @(negedge CLK);
      CLR = 1'b0;
      #1;
      chk("clr_in_ready", 128'(in_ready), 128'(1));

      // Randomised traffic.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom % 4) != 0, 16'($urandom) | 16'h1, rops(), 4'($urandom),
              ($urandom % 3) != 0, ($urandom % 25) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

`default_nettype wire
